parity_frame_checker: RTL

Parametrised serial parity checker for framed bit streams; next generation of the team's 8-bit serial parity block. It accepts one bit per qualified cycle: DATA_W data bits LSB-first, then one parity bit. Per frame it reports the captured word, a pass/fail result and a completion strobe. A saturating error counter and a synchronous frame abort support link-level monitoring. It sits between the serial receive front end and the word-level consumer.

---
 rtl/parity_pkg.sv | 15 +
 rtl/parity_frame_checker_if.sv | 31 +++
 rtl/parity_err_counter.sv | 26 ++
 rtl/parity_frame_checker.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the framed serial parity checker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_checker_if.sv
// Serial-in / word-out bundle between the receive front end and the checker.
// Latency: n/a (wiring only).
// Backpressure: none; the checker always accepts a qualified beat.
interface parity_frame_checker_if #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              data_in;
    logic              valid;
    logic              mode;
    logic              frame_abort;
    logic [CNT_W-1:0]  bit_count;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              parity_ok;
    logic              frame_done;
    logic              parity_err;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output data_in, valid, mode, frame_abort,
        input  bit_count, busy, data_out, parity_ok, frame_done, parity_err, err_count
    );

    modport slave (
        input  data_in, valid, mode, frame_abort,
        output bit_count, busy, data_out, parity_ok, frame_done, parity_err, err_count
    );
endinterface

// File: rtl/parity_err_counter.sv
// Saturating counter of failed frames; sticks at all-ones.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; inc is a single-cycle pulse.
module parity_err_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] r_count;

    // Increment on each failing frame, holding once the counter is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {ERR_W{1'b1}})) begin
            r_count <= r_count + ERR_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/parity_frame_checker.sv
// Frames DATA_W serial bits (LSB first) plus one parity bit and checks parity.
// Latency: result and frame_done one clock after the parity beat is accepted.
// Backpressure: none; every qualified beat is taken, abort discards the frame.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1),
    parameter int ERR_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    parity_frame_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_parity_beat;
    logic              w_final;
    logic              w_ok;
    logic              w_err_inc;

    logic [DATA_W-1:0] r_shift;
    logic              r_acc;
    logic              r_mode_q;
    logic [CNT_W-1:0]  r_bit_count;
    logic              r_busy;
    logic [DATA_W-1:0] r_data_out;
    logic              r_parity_ok;
    logic              r_frame_done;
    logic              r_parity_err;
    logic [ERR_W-1:0]  w_err_count;

    // A beat counts only when qualified and not overridden by an abort.
    assign w_accept  = bus.valid && !bus.frame_abort;
    assign w_final   = r_acc ^ bus.data_in;
    assign w_ok      = (r_mode_q == MODE_ODD) ? w_final : !w_final;
    assign w_err_inc = w_parity_beat && !w_ok;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort returns to IDLE from anywhere.
    always_comb begin
        w_next_state  = r_state;
        w_parity_beat = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_accept && (r_bit_count == LAST_IDX)) begin
                    w_next_state = PARITY;
                end
            end
            PARITY: begin
                if (w_accept) begin
                    w_next_state  = IDLE;
                    w_parity_beat = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (bus.frame_abort) begin
            w_next_state = IDLE;
        end
    end

    // Datapath: capture bits, fold parity, publish the result on the parity beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift      <= '0;
            r_acc        <= 1'b0;
            r_mode_q     <= MODE_EVEN;
            r_bit_count  <= '0;
            r_busy       <= 1'b0;
            r_data_out   <= '0;
            r_parity_ok  <= 1'b0;
            r_frame_done <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_parity_err <= 1'b0;
            if (bus.frame_abort) begin
                r_bit_count <= '0;
                r_busy      <= 1'b0;
            end else if (bus.valid) begin
                case (r_state)
                    IDLE: begin
                        r_shift     <= {{(DATA_W-1){1'b0}}, bus.data_in};
                        r_acc       <= bus.data_in;
                        r_mode_q    <= bus.mode;
                        r_bit_count <= CNT_W'(1);
                        r_busy      <= 1'b1;
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_bit_count == CNT_W'(i)) begin
                                r_shift[i] <= bus.data_in;
                            end
                        end
                        r_acc       <= r_acc ^ bus.data_in;
                        r_bit_count <= r_bit_count + CNT_W'(1);
                    end
                    PARITY: begin
                        r_data_out   <= r_shift;
                        r_parity_ok  <= w_ok;
                        r_parity_err <= !w_ok;
                        r_frame_done <= 1'b1;
                        r_bit_count  <= '0;
                        r_busy       <= 1'b0;
                    end
                    default: begin
                        r_bit_count <= '0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    parity_err_counter #(
        .ERR_W (ERR_W)
    ) u_err_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_err_inc),
        .count   (w_err_count)
    );

    assign bus.bit_count  = r_bit_count;
    assign bus.busy       = r_busy;
    assign bus.data_out   = r_data_out;
    assign bus.parity_ok  = r_parity_ok;
    assign bus.frame_done = r_frame_done;
    assign bus.parity_err = r_parity_err;
    assign bus.err_count  = w_err_count;

endmodule
